ifetch_prefetch: RTL
====================

Name: ifetch_prefetch

Overview:
- Instruction fetch stage between the PC/next-PC logic and instruction memory.
- Issues in-order requests to a variable-latency instruction memory and buffers returned words with their PC in a small FIFO.
- Presents {pc, instruction} to decode over a valid/ready handshake.
- Branch/jump redirect flushes the buffer and discards responses that are still in flight.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- redirect  in  1  taken branch/jump; flush and restart fetch.
- redirect_pc  in  32  restart address; bits [1:0] ignored (treated as 00).
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode consumes head.
- inst_pc  out  32  PC of head entry.
- inst_data  out  32  instruction of head entry.
- outstanding  out  $clog2(DEPTH)+1  requests accepted but not yet responded to (includes ones to be dropped).

Behaviour:
- Reset, synchronous, active-high; applies to all of the following:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty, outstanding=0, drop_cnt=0.
  - imem_req_valid=0, inst_valid=0, inst_pc=0, inst_data=0.
  - Reset mid-transaction abandons everything; responses arriving after reset deassertion for pre-reset requests are the memory's responsibility. The bench holds the memory idle during reset.
- Credit rule: imem_req_valid = !reset && !redirect && (fifo_count + outstanding < DEPTH).
  - The FIFO can never overflow.
  - imem_addr = fetch_pc.
- Request handshake:
  - Accepted when imem_req_valid && imem_req_ready; then fetch_pc += 4 and outstanding += 1.
  - While valid && !ready, imem_addr must stay stable.
  - The only permitted withdrawal of an unaccepted request is a redirect cycle.
- Response:
  - Every imem_rsp_valid decrements outstanding. A simultaneous accept and response leaves it unchanged.
  - If drop_cnt > 0: discard the word and decrement drop_cnt.
  - Otherwise push {resp_pc, imem_rsp_data} and resp_pc += 4.
- Output:
  - inst_valid = FIFO non-empty; inst_pc/inst_data = head entry (registered, no bypass).
  - A response in cycle M is visible on inst_* in cycle M+1 at the earliest.
  - Pop on inst_valid && inst_ready.
  - Simultaneous push and pop keeps the count unchanged and is legal at full or empty.
- Redirect (cycle N):
  - FIFO cleared at the end of N, so inst_valid=0 in N+1. A pop in N is ignored (flush wins).
  - fetch_pc and resp_pc are set to {redirect_pc[31:2],2'b00}.
  - No request is issued in N.
  - drop_cnt <= outstanding - imem_rsp_valid. Any response in N is itself discarded.
  - First request with the new address appears in N+1.
  - Minimum redirect-to-inst_valid latency = 2 + memory response latency.
  - Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
- Address arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- Invariants (assert in bench):
  - drop_cnt <= outstanding.
  - fifo_count + outstanding <= DEPTH.
  - inst_pc increments by 4 between consecutive pops unless a redirect occurs between them.

Test Plan:
- Reset, memory always ready, 1-cycle latency, inst_ready=1 -> imem_addr 0,4,8,...; inst_pc 0,4,8,... with matching data; steady state one instruction per cycle after a 2-cycle fill.
- inst_ready=0 with DEPTH=4 -> exactly 4 requests issued (0x0..0xC), FIFO full, imem_req_valid=0, outstanding=0; raising inst_ready drains 0x0..0xC in order, then fetching resumes at 0x10.
- 3-cycle latency with 2 requests outstanding; redirect to 0x0000_0103 -> both stale responses discarded (drop_cnt 2->0), next inst_pc=0x100, no stale PC ever appears on inst_valid.
- Redirect in the same cycle as imem_rsp_valid and an inst_valid&&inst_ready pop -> response dropped, pop ignored, FIFO empty next cycle, first new request in the following cycle.
- imem_req_ready held low 5 cycles -> imem_addr stable at 0x8 throughout; a redirect in cycle 3 changes the address to the target from the next cycle and 0x8 is never accepted.
- Redirect to 0xFFFF_FFF8 -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; reset asserted mid-stream -> all outputs 0 and the next fetch at RESET_PC.

Source files
------------

// File: rtl/ifetch_prefetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response, decode-side {pc, inst} handshake.
// master = fetch unit, slave = surrounding core/memory.
interface ifetch_prefetch_if #(
    parameter int DEPTH = 4
);
    logic                     redirect;
    logic [31:0]              redirect_pc;
    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [31:0]              imem_addr;
    logic                     imem_rsp_valid;
    logic [31:0]              imem_rsp_data;
    logic                     inst_valid;
    logic                     inst_ready;
    logic [31:0]              inst_pc;
    logic [31:0]              inst_data;
    logic [$clog2(DEPTH):0]   outstanding;

    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_addr, inst_valid, inst_pc, inst_data, outstanding
    );

    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_addr, inst_valid, inst_pc, inst_data, outstanding
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch: in-order imem requests, {pc, inst} FIFO to decode; response visible 1 cycle later.
// Requests are credit-limited so FIFO + in-flight never exceed DEPTH; redirect flushes and drops stale responses.
module ifetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    ifetch_prefetch_if.master bus
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   C_ONE   = CW'(1);
    localparam logic [PW-1:0]   P_ONE   = PW'(1);
    localparam logic [CW:0]     DEPTH_L = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   dat_mem [DEPTH];

    logic          credit_ok;
    logic          req_valid;
    logic          accept;
    logic          drop;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [31:0]   target_pc;

    // Credits count both buffered words and words still owed by memory.
    assign credit_ok  = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_L;
    assign req_valid  = !reset && !bus.redirect && credit_ok;
    assign accept     = req_valid && bus.imem_req_ready;
    assign drop       = bus.imem_rsp_valid && (drop_cnt != '0);
    assign push       = bus.imem_rsp_valid && !drop && !bus.redirect;
    assign head_valid = (count != '0);
    assign pop        = head_valid && bus.inst_ready && !bus.redirect;
    assign target_pc  = bus.redirect_pc & 32'hFFFF_FFFC;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = fetch_pc;
    assign bus.inst_valid     = head_valid;
    assign bus.inst_pc        = head_valid ? pc_mem[rd_ptr]  : '0;
    assign bus.inst_data      = head_valid ? dat_mem[rd_ptr] : '0;
    assign bus.outstanding    = outstanding;

    always_comb begin
        outstanding_nxt = outstanding;
        if (accept && !bus.imem_rsp_valid) begin
            outstanding_nxt = outstanding + C_ONE;
        end else if (!accept && bus.imem_rsp_valid) begin
            outstanding_nxt = outstanding - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= resp_pc;
            dat_mem[wr_ptr] <= bus.imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (bus.redirect) begin
                // A response landing in the redirect cycle is already stale, so it is not counted again.
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                drop_cnt <= outstanding - (bus.imem_rsp_valid ? C_ONE : '0);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (drop) begin
                    drop_cnt <= drop_cnt - C_ONE;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + P_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + P_ONE;
                end
                if (push && !pop) begin
                    count <= count + C_ONE;
                end else if (pop && !push) begin
                    count <= count - C_ONE;
                end
            end
        end
    end
endmodule
